// File: rtl/m_wb_uart_if.sv
// m_wb_uart_if: Wishbone slave bus between the midgetv core and the UART
//   CYC_I/STB_I/WE_I : cycle, strobe, write enable (master -> slave)
//   ADR_I            : register select, 0 = DATA, 1 = STATUS
//   DAT_I / DAT_O    : write data / read data
//   ACK_O            : registered acknowledge (slave -> master)
interface m_wb_uart_if;
  logic        CYC_I;
  logic        STB_I;
  logic        WE_I;
  logic        ADR_I;
  logic [31:0] DAT_I;
  logic [31:0] DAT_O;
  logic        ACK_O;
  modport master (output CYC_I, STB_I, WE_I, ADR_I, DAT_I, input DAT_O, ACK_O);
  modport slave  (input CYC_I, STB_I, WE_I, ADR_I, DAT_I, output DAT_O, ACK_O);
endinterface

// File: rtl/m_wb_uart.sv
// m_wb_uart: Wishbone UART, 8N1, one TX holding register and one RX data register
//   CLK_I, RST_I : clock, asynchronous active-high reset
//   wb           : Wishbone slave port (m_wb_uart_if.slave)
//   usartRX      : asynchronous serial input
//   usartTX      : registered serial output
module m_wb_uart #(
  parameter int CLKDIV = 208
) (
  input  logic       CLK_I,
  input  logic       RST_I,
  m_wb_uart_if.slave wb,
  input  logic       usartRX,
  output logic       usartTX
);
  localparam logic [15:0] LP_FULL = 16'(CLKDIV - 1);
  localparam logic [15:0] LP_HALF = 16'(CLKDIV / 2 - 1);
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} t_state;
  t_state r_tx_st, w_tx_st, r_rx_st, w_rx_st;
  logic [15:0] r_tx_cnt, w_tx_cnt, r_rx_cnt, w_rx_cnt;
  logic [2:0] r_tx_bit, w_tx_bit, r_rx_bit, w_rx_bit;
  logic [7:0] r_hold, w_hold, r_tx_sh, w_tx_sh, r_rx_sh, w_rx_sh, r_rxdata, w_rxdata;
  logic r_txfull, w_txfull, r_rxvalid, w_rxvalid, r_ovr, w_ovr, r_ferr, w_ferr;
  logic r_tx, w_tx, r_ack, r_rx_s1, r_rx_s2, r_rx_prev;
  logic w_acc, w_wr, w_rd, w_rx_done;
  assign w_acc = wb.CYC_I & wb.STB_I & ~r_ack;
  assign w_wr = w_acc & wb.WE_I & ~wb.ADR_I;
  assign w_rd = w_acc & ~wb.WE_I & ~wb.ADR_I;
  assign wb.ACK_O = r_ack;
  assign wb.DAT_O = wb.ADR_I ? {28'h0, r_ferr, r_ovr, r_rxvalid, r_txfull} : {24'h0, r_rxdata};
  assign usartTX = r_tx;
  assign w_hold = (w_wr & ~r_txfull) ? wb.DAT_I[7:0] : r_hold;
  // a byte completing in the read cycle keeps rxvalid; an overrun keeps the old byte
  assign w_rxvalid = w_rx_done | (r_rxvalid & ~w_rd);
  assign w_ovr = (w_rx_done & r_rxvalid) | (r_ovr & ~w_rd);
  assign w_ferr = (w_rx_done & ~r_rxvalid) ? ~r_rx_s2 : (r_ferr & ~w_rd);
  assign w_rxdata = (w_rx_done & ~r_rxvalid) ? r_rx_sh : r_rxdata;
  always_comb begin
    w_tx_st = r_tx_st;
    w_tx_cnt = (r_tx_cnt != 16'd0) ? r_tx_cnt - 16'd1 : 16'd0;
    w_tx_bit = r_tx_bit;
    w_tx_sh = r_tx_sh;
    w_txfull = r_txfull | w_wr;
    case (r_tx_st)
      S_IDLE: if (r_txfull) begin
        w_tx_st = S_START;
        w_tx_cnt = LP_FULL;
        w_tx_sh = r_hold;
        w_txfull = 1'b0;
      end
      S_START: if (r_tx_cnt == 16'd0) begin
        w_tx_st = S_DATA;
        w_tx_cnt = LP_FULL;
        w_tx_bit = 3'd0;
      end
      S_DATA: if (r_tx_cnt == 16'd0) begin
        w_tx_cnt = LP_FULL;
        w_tx_bit = r_tx_bit + 3'd1;
        w_tx_sh = r_tx_sh >> 1;
        if (r_tx_bit == 3'd7) w_tx_st = S_STOP;
      end
      // the IDLE cycle that follows is the last cycle of the stop bit
      S_STOP: if (r_tx_cnt == 16'd1) w_tx_st = S_IDLE;
    endcase
    w_tx = (w_tx_st == S_START) ? 1'b0 : (w_tx_st == S_DATA) ? w_tx_sh[0] : 1'b1;
  end
  always_comb begin
    w_rx_st = r_rx_st;
    w_rx_cnt = (r_rx_cnt != 16'd0) ? r_rx_cnt - 16'd1 : 16'd0;
    w_rx_bit = r_rx_bit;
    w_rx_sh = r_rx_sh;
    w_rx_done = 1'b0;
    case (r_rx_st)
      S_IDLE: if (r_rx_prev & ~r_rx_s2) begin
        w_rx_st = S_START;
        w_rx_cnt = LP_HALF;
      end
      S_START: if (r_rx_cnt == 16'd0) begin
        w_rx_st = r_rx_s2 ? S_IDLE : S_DATA;
        w_rx_cnt = r_rx_s2 ? 16'd0 : LP_FULL;
        w_rx_bit = 3'd0;
      end
      S_DATA: if (r_rx_cnt == 16'd0) begin
        w_rx_sh = {r_rx_s2, r_rx_sh[7:1]};
        w_rx_cnt = LP_FULL;
        w_rx_bit = r_rx_bit + 3'd1;
        if (r_rx_bit == 3'd7) w_rx_st = S_STOP;
      end
      S_STOP: if (r_rx_cnt == 16'd0) begin
        w_rx_done = 1'b1;
        w_rx_st = S_IDLE;
      end
    endcase
  end
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      r_tx_st <= S_IDLE;
      r_rx_st <= S_IDLE;
      r_tx_cnt <= 16'd0;
      r_rx_cnt <= 16'd0;
      r_tx_bit <= 3'd0;
      r_rx_bit <= 3'd0;
      r_hold <= 8'd0;
      r_tx_sh <= 8'd0;
      r_rx_sh <= 8'd0;
      r_rxdata <= 8'd0;
      r_txfull <= 1'b0;
      r_rxvalid <= 1'b0;
      r_ovr <= 1'b0;
      r_ferr <= 1'b0;
      r_tx <= 1'b1;
      r_ack <= 1'b0;
      r_rx_s1 <= 1'b1;
      r_rx_s2 <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_tx_st <= w_tx_st;
      r_rx_st <= w_rx_st;
      r_tx_cnt <= w_tx_cnt;
      r_rx_cnt <= w_rx_cnt;
      r_tx_bit <= w_tx_bit;
      r_rx_bit <= w_rx_bit;
      r_hold <= w_hold;
      r_tx_sh <= w_tx_sh;
      r_rx_sh <= w_rx_sh;
      r_rxdata <= w_rxdata;
      r_txfull <= w_txfull;
      r_rxvalid <= w_rxvalid;
      r_ovr <= w_ovr;
      r_ferr <= w_ferr;
      r_tx <= w_tx;
      r_ack <= wb.CYC_I & wb.STB_I & ~r_ack;
      r_rx_s1 <= usartRX;
      r_rx_s2 <= r_rx_s1;
      r_rx_prev <= r_rx_s2;
    end
  end
endmodule

// File: tb/tb_m_wb_uart.sv
// tb_m_wb_uart: self-checking bench for m_wb_uart with CLKDIV=4
module tb_m_wb_uart;
  localparam int P = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx = 1'b1;
  logic tx;
  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  m_wb_uart_if bus();
  m_wb_uart #(.CLKDIV(P)) dut (.CLK_I(clk), .RST_I(rst), .wb(bus), .usartRX(rx), .usartTX(tx));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // line monitor: decodes every frame seen on usartTX and checks bit widths
  logic [7:0] txq[$];
  logic txok[$];
  int txst[$];
  logic ln [10*P];
  logic [7:0] mb;
  logic mok;
  int mst;
  logic prev_tx = 1'b1;
  initial forever begin
    @(negedge clk);
    if (prev_tx && !tx) begin
      mst = cyc;
      ln[0] = tx;
      for (int i = 1; i < 10*P; i++) begin
        @(negedge clk);
        ln[i] = tx;
      end
      mok = (ln[0] == 1'b0) && (ln[9*P] == 1'b1);
      for (int j = 0; j < 10*P; j++) if (ln[j] !== ln[(j/P)*P]) mok = 1'b0;
      for (int k = 0; k < 8; k++) mb[k] = ln[(k+1)*P];
      txq.push_back(mb);
      txok.push_back(mok);
      txst.push_back(mst);
      prev_tx = ln[10*P-1];
    end else prev_tx = tx;
  end

  task automatic wb(input logic we, input logic adr, input logic [31:0] d, output logic [31:0] q);
    int lat = 0;
    @(negedge clk);
    bus.CYC_I = 1'b1;
    bus.STB_I = 1'b1;
    bus.WE_I = we;
    bus.ADR_I = adr;
    bus.DAT_I = d;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.ACK_O && lat < 8);
    q = bus.DAT_O;
    chk("ack_latency", lat, 1);
    bus.CYC_I = 1'b0;
    bus.STB_I = 1'b0;
    bus.WE_I = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rx = f[i];
      repeat (P - 1) @(negedge clk);
    end
    @(negedge clk);
    rx = 1'b1;
    repeat (P) @(negedge clk);
  endtask

  task automatic wait_tx(input int n);
    int t = 0;
    while (txq.size() < n && t < 600) begin
      @(negedge clk);
      t++;
    end
    chk("tx_frame_count", txq.size(), n);
  endtask

  task automatic chk_frame(input int i, input logic [7:0] exp);
    chk("tx_byte", {24'h0, txq[i]}, {24'h0, exp});
    chk("tx_format", {31'h0, txok[i]}, 32'h1);
  endtask

  typedef struct {
    logic we;
    logic adr;
    logic [7:0] d;
    logic rd;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl[11];
  logic [31:0] q;
  logic [3:0] pat;
  logic [7:0] rb, exp_tx[$];
  logic rstop, m_v, m_o, m_f;
  logic [7:0] m_d;
  int act;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    bus.CYC_I = 1'b0;
    bus.STB_I = 1'b0;
    bus.WE_I = 1'b0;
    bus.ADR_I = 1'b0;
    bus.DAT_I = 32'h0;
    tbl[0] = '{1'b0, 1'b1, 8'h00, 1'b1, 32'h0};
    tbl[1] = '{1'b0, 1'b0, 8'h00, 1'b1, 32'h0};
    tbl[2] = '{1'b1, 1'b1, 8'hFF, 1'b0, 32'h0};
    tbl[3] = '{1'b0, 1'b1, 8'h00, 1'b1, 32'h0};
    tbl[4] = '{1'b1, 1'b0, 8'h5A, 1'b0, 32'h0};
    tbl[5] = '{1'b0, 1'b1, 8'h00, 1'b1, 32'h0};
    tbl[6] = '{1'b1, 1'b0, 8'hC3, 1'b0, 32'h0};
    tbl[7] = '{1'b0, 1'b1, 8'h00, 1'b1, 32'h1};
    tbl[8] = '{1'b1, 1'b0, 8'hFF, 1'b0, 32'h0};
    tbl[9] = '{1'b0, 1'b1, 8'h00, 1'b1, 32'h1};
    tbl[10] = '{1'b0, 1'b0, 8'h00, 1'b1, 32'h0};
    repeat (3) @(negedge clk);
    chk("rst_tx", {31'h0, tx}, 32'h1);
    chk("rst_ack", {31'h0, bus.ACK_O}, 32'h0);
    bus.ADR_I = 1'b1;
    #1 chk("rst_status", bus.DAT_O, 32'h0);
    bus.ADR_I = 1'b0;
    #1 chk("rst_data", bus.DAT_O, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    // register-level table
    for (int i = 0; i < 11; i++) begin
      wb(tbl[i].we, tbl[i].adr, {24'h0, tbl[i].d}, q);
      if (tbl[i].rd) chk($sformatf("table_%0d", i), q, tbl[i].exp);
    end
    wait_tx(2);
    chk_frame(0, 8'h5A);
    chk_frame(1, 8'hC3);
    repeat (60) @(negedge clk);
    chk("table_no_drop_frame", txq.size(), 2);
    txq.delete(); txok.delete(); txst.delete();
    // single byte 0x55
    wb(1'b1, 1'b0, 32'h55, q);
    wait_tx(1);
    chk_frame(0, 8'h55);
    wb(1'b0, 1'b1, 32'h0, q);
    chk("status_after_tx", q, 32'h0);
    repeat (10) @(negedge clk);
    txq.delete(); txok.delete(); txst.delete();
    // back-to-back with a dropped third write
    wb(1'b1, 1'b0, 32'hA5, q);
    wb(1'b1, 1'b0, 32'h3C, q);
    wb(1'b1, 1'b0, 32'hFF, q);
    wait_tx(2);
    chk_frame(0, 8'hA5);
    chk_frame(1, 8'h3C);
    chk("b2b_start_spacing", txst[1] - txst[0], 10*P);
    repeat (60) @(negedge clk);
    chk("dropped_write", txq.size(), 2);
    txq.delete(); txok.delete(); txst.delete();
    // RX single frame
    send_frame(8'h96, 1'b1);
    wb(1'b0, 1'b1, 32'h0, q);
    chk("rx_status_valid", q, 32'h2);
    wb(1'b0, 1'b0, 32'h0, q);
    chk("rx_data", q, 32'h96);
    wb(1'b0, 1'b1, 32'h0, q);
    chk("rx_status_cleared", q, 32'h0);
    // overrun
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    wb(1'b0, 1'b1, 32'h0, q);
    chk("ovr_status", q, 32'h6);
    wb(1'b0, 1'b0, 32'h0, q);
    chk("ovr_data", q, 32'h11);
    wb(1'b0, 1'b1, 32'h0, q);
    chk("ovr_cleared", q, 32'h0);
    // framing error, then a one-cycle glitch
    send_frame(8'h5A, 1'b0);
    wb(1'b0, 1'b1, 32'h0, q);
    chk("ferr_status", q, 32'hA);
    wb(1'b0, 1'b0, 32'h0, q);
    chk("ferr_data", q, 32'h5A);
    @(negedge clk);
    rx = 1'b0;
    @(negedge clk);
    rx = 1'b1;
    repeat (12*P) @(negedge clk);
    wb(1'b0, 1'b1, 32'h0, q);
    chk("glitch_status", q, 32'h0);
    // held strobe never gets two consecutive ACK cycles
    @(negedge clk);
    bus.CYC_I = 1'b1;
    bus.STB_I = 1'b1;
    bus.WE_I = 1'b0;
    bus.ADR_I = 1'b1;
    pat = 4'h0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      pat = {pat[2:0], bus.ACK_O};
    end
    chk("ack_pattern", {28'h0, pat}, 32'hA);
    bus.CYC_I = 1'b0;
    bus.STB_I = 1'b0;
    // reset in the middle of data bit 3
    wb(1'b1, 1'b0, 32'hF0, q);
    repeat (18) @(negedge clk);
    chk("tx_bit3_low", {31'h0, tx}, 32'h0);
    #2 rst = 1'b1;
    #1 chk("async_rst_tx", {31'h0, tx}, 32'h1);
    chk("async_rst_ack", {31'h0, bus.ACK_O}, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wb(1'b0, 1'b1, 32'h0, q);
    chk("post_rst_status", q, 32'h0);
    repeat (50) @(negedge clk);
    txq.delete(); txok.delete(); txst.delete();
    wb(1'b1, 1'b0, 32'h3C, q);
    wait_tx(1);
    chk_frame(0, 8'h3C);
    repeat (10) @(negedge clk);
    txq.delete(); txok.delete(); txst.delete();
    // random RX traffic against a flag model, with TX running concurrently
    m_v = 1'b0; m_o = 1'b0; m_f = 1'b0; m_d = 8'h0;
    for (int it = 0; it < 10; it++) begin
      rb = 8'($urandom);
      exp_tx.push_back(rb);
      wb(1'b1, 1'b0, {24'h0, rb}, q);
      rb = 8'($urandom);
      rstop = ($urandom_range(0, 3) != 0);
      send_frame(rb, rstop);
      if (!m_v) begin
        m_d = rb;
        m_v = 1'b1;
        m_f = ~rstop;
      end else m_o = 1'b1;
      act = $urandom_range(0, 2);
      if (act != 0) begin
        wb(1'b0, 1'b1, 32'h0, q);
        chk("rand_status", q, {28'h0, m_f, m_o, m_v, 1'b0});
      end
      if (act == 2) begin
        wb(1'b0, 1'b0, 32'h0, q);
        chk("rand_data", q, {24'h0, m_d});
        m_v = 1'b0; m_o = 1'b0; m_f = 1'b0;
      end
    end
    wait_tx(exp_tx.size());
    for (int i = 0; i < exp_tx.size(); i++) chk_frame(i, exp_tx[i]);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
